bcd_display_driver: RTL and testbench
=====================================

Name: bcd_display_driver

Overview:
- Consumes the two-digit BCD count (tens, ones) from the 01–99 counter and drives a 2-digit, common-anode, time-multiplexed seven-segment display.
- Tens code 4'b1111 means "blank digit" and is honoured.
- Digits are captured on an update strobe, so the display stays glitch-free while the counter changes.
- Sits between the counter and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is held before the scan switches to the other digit; legal range ≥2. Counter width is $clog2(REFRESH_DIV).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- tens  in  4  tens digit; 0–9 digit, 4'b1111 blank, 10–14 invalid.
- ones  in  4  ones digit; same encoding as tens.
- update  in  1  single-cycle strobe; capture tens/ones this cycle.
- seg_n  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- an_n  out  2  anode enables, active-low; [0]=ones, [1]=tens.
- blink  in  1  present only when DISP_BLINK_EN is defined.

Behaviour:
- Reset: synchronous, taken only on the rising edge with reset_n=0. Values after reset:
  - div_cnt=0, digit_sel=0 (ones).
  - tens_q=4'b1111, ones_q=4'b0000.
  - seg_n=7'b1111111, an_n=2'b11.
- Reset asserted mid-scan or mid-update: the same values apply; a coincident update is discarded.
- Capture: on an edge where update=1, tens_q<=tens and ones_q<=ones. With update=0, the hold registers keep their value. Inputs are ignored without update.
- Prescaler: div_cnt increments each cycle. At div_cnt==REFRESH_DIV-1 it wraps to 0 and digit_sel toggles on the same edge. Each digit is therefore active for exactly REFRESH_DIV cycles.
- Output stage (registered): on every edge, seg_n/an_n are loaded from the decode of the hold register selected by the current digit_sel.
  - Outputs lag digit_sel by 1 cycle.
  - Outputs lag a captured value by 1 cycle after the capture edge, provided that digit is selected.
- An update coinciding with a digit_sel toggle: the new hold value and the new selection both take effect at the following edge. No mixed output is permitted.
- Decode:
  - 0–9 → standard patterns. 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
  - 10–14 → dash, 7'b0111111.
  - 15 → blank: seg_n=7'b1111111 and that digit's an_n bit = 1.
- an_n: exactly one bit low when the selected digit is not blank, else 2'b11. Never 2'b00.

Optional Feature:
- Macro: DISP_BLINK_EN.
- Defined:
  - Adds the blink input and a 1-bit blink phase that toggles every 16 digit_sel toggles.
  - While blink=1 and phase=1, outputs are forced to seg_n=7'b1111111 and an_n=2'b11. The scan and capture logic continue unaffected.
  - blink=0 → normal display; the phase counter still runs.
  - The phase counter resets to 0.
- Undefined: no blink port, no phase logic, behaviour exactly as above.

Decomposition:
- Package disp_pkg holds:
  - BLANK_CODE=4'hF.
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - Typedef seg_t (logic [6:0]) and a bcd_t (logic [3:0]) typedef.
  - Constant array of the ten digit patterns.
- Sub-module bcd_to_7seg: purely combinational bcd_t → seg_t plus a blank flag. It is instantiated once, on the muxed hold value. The registers live in the parent.

Test Plan (REFRESH_DIV=4):
1. Reset, then release with no update → first edge ones digit 0: seg_n=7'b1000000, an_n=2'b10. After 4 cycles the tens digit (blank) is selected: seg_n=7'b1111111, an_n=2'b11. The two states alternate every 4 cycles.
2. update with tens=4'd4, ones=4'd2 → next ones slot seg_n=7'b0100100/an_n=2'b10; tens slot seg_n=7'b0011001/an_n=2'b01.
3. tens=4'd1 and ones changed while update=0 → display unchanged. Pulse update → new values appear 1 cycle after capture in the selected slot.
4. update asserted on the same edge as the digit_sel toggle (tens=7, ones=9) → next output is the newly selected digit with the new value (7'b1111000 or 7'b0010000). No stale or mixed digit appears.
5. ones=4'd12 → dash 7'b0111111. tens=4'hF → an_n[1] stays 1 for the whole tens slot. Reset asserted mid-slot → the next edge gives seg_n=7'b1111111, an_n=2'b11, and the scan restarts from ones.
6. (DISP_BLINK_EN) blink=1 → after 16 toggles outputs are held at 7'b1111111/2'b11 for 16 toggles, then the display resumes. blink=0 → normal scan throughout.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared digit/segment types and seven-segment constants for the BCD display driver.
package disp_pkg;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  localparam bcd_t BLANK_CODE = 4'hF;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t DIGIT_SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/bcd_display_driver_if.sv
// bcd_display_driver_if: digit inputs, capture strobe and display pins; blink exists only with DISP_BLINK_EN.
interface bcd_display_driver_if;
  disp_pkg::bcd_t tens;
  disp_pkg::bcd_t ones;
  logic update;
  disp_pkg::seg_t seg_n;
  logic [1:0] an_n;
`ifdef DISP_BLINK_EN
  logic blink;
  modport master(output tens, ones, update, blink, input seg_n, an_n);
  modport slave(input tens, ones, update, blink, output seg_n, an_n);
`else
  modport master(output tens, ones, update, input seg_n, an_n);
  modport slave(input tens, ones, update, output seg_n, an_n);
`endif
endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD to active-low segment decode with blank flag.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg,
  output logic blank
);
  assign blank = bcd == BLANK_CODE;
  assign seg = bcd < 4'd10 ? DIGIT_SEG[bcd] : blank ? SEG_BLANK : SEG_DASH;
endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: captures two BCD digits on update and scans them onto a 2-digit common-anode display.
// Optional blanking blink enabled by DISP_BLINK_EN.
module bcd_display_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input logic clock,
  input logic reset_n,
  bcd_display_driver_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic digit_sel_q, digit_sel_d, wrap, cur_blank;
  bcd_t tens_q, tens_d, ones_q, ones_d, cur;
  seg_t seg_n_q, seg_n_d, cur_seg;
  logic [1:0] an_n_q, an_n_d;
  logic force_off;
  assign cur = digit_sel_q ? tens_q : ones_q;
  bcd_to_7seg u_dec (.bcd(cur), .seg(cur_seg), .blank(cur_blank));
`ifdef DISP_BLINK_EN
  logic [3:0] tog_cnt_q, tog_cnt_d;
  logic phase_q, phase_d;
  always_comb begin
    tog_cnt_d = tog_cnt_q + 4'(wrap);
    phase_d = phase_q ^ (wrap && tog_cnt_q == 4'hF);
    force_off = bus.blink && phase_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tog_cnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      tog_cnt_q <= tog_cnt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign force_off = 1'b0;
`endif
  // Output stage decodes the pre-edge selection and hold values, so a coincident update/toggle never mixes.
  always_comb begin
    wrap = div_cnt_q == CW'(REFRESH_DIV - 1);
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    digit_sel_d = digit_sel_q ^ wrap;
    tens_d = bus.update ? bus.tens : tens_q;
    ones_d = bus.update ? bus.ones : ones_q;
    seg_n_d = force_off ? SEG_BLANK : cur_seg;
    an_n_d = (force_off || cur_blank) ? 2'b11 : digit_sel_q ? 2'b01 : 2'b10;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      digit_sel_q <= 1'b0;
      tens_q <= BLANK_CODE;
      ones_q <= 4'd0;
      seg_n_q <= SEG_BLANK;
      an_n_q <= 2'b11;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_sel_q <= digit_sel_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      seg_n_q <= seg_n_d;
      an_n_q <= an_n_d;
    end
  end
  assign bus.seg_n = seg_n_q;
  assign bus.an_n = an_n_q;
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: randomized self-checking bench against a time-based reference model of the scan.
module tb_bcd_display_driver;
  import disp_pkg::*;
  localparam int RD = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n = 0;
  bcd_t ht = 4'hF, ho = 4'h0;
  seg_t exp_seg = 7'h7F;
  logic [1:0] exp_an = 2'b11;
  logic blink_v = 1'b0;
  seg_t ref_tab [16];
  bcd_display_driver_if bus();
  bcd_display_driver #(.REFRESH_DIV(RD)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  initial begin
    ref_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                7'b1111111};
  end
  // n counts edges since reset; the digit shown at edge n is the one selected for slot n/RD.
  task automatic cycle(input bcd_t t, input bcd_t o, input logic u, input logic r);
    logic sel;
    bcd_t d;
    logic off;
    @(negedge clock);
    bus.tens = t;
    bus.ones = o;
    bus.update = u;
    reset_n = r;
`ifdef DISP_BLINK_EN
    bus.blink = blink_v;
`endif
    @(posedge clock);
    if (!r) begin
      n = 0;
      ht = 4'hF;
      ho = 4'h0;
      exp_seg = 7'h7F;
      exp_an = 2'b11;
    end else begin
      sel = ((n / RD) % 2) == 1;
      d = sel ? ht : ho;
      off = 1'b0;
`ifdef DISP_BLINK_EN
      off = blink_v && (((n / RD) / 16) % 2 == 1);
`endif
      exp_seg = off ? 7'h7F : ref_tab[d];
      exp_an = (off || d == 4'hF) ? 2'b11 : sel ? 2'b01 : 2'b10;
      if (u) begin
        ht = t;
        ho = o;
      end
      n++;
    end
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'd8, 4'd8, 1'b1, 1'b0);
      checks++;
      if (bus.seg_n !== 7'b1111111 || bus.an_n !== 2'b11) begin
        errors++;
        $display("FAIL reset: seg_n=%b an_n=%b expected 1111111 11", bus.seg_n, bus.an_n);
      end
    end
    for (int i = 0; i < 17; i++) begin
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b1);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an) begin
        errors++;
        $display("FAIL idle_scan[%0d]: seg_n=%b an_n=%b expected %b %b", i, bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
  endtask
  task automatic test_capture();
    cycle(4'd4, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(4'd4, 4'd2, 1'b0, 1'b1);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an) begin
        errors++;
        $display("FAIL capture[%0d]: seg_n=%b an_n=%b expected %b %b", i, bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
  endtask
  task automatic test_hold_without_update();
    for (int i = 0; i < 10; i++) begin
      cycle(4'd1, 4'($urandom_range(0, 9)), 1'b0, 1'b1);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an || (bus.an_n !== 2'b10 && bus.an_n !== 2'b01)) begin
        errors++;
        $display("FAIL hold: seg_n=%b an_n=%b expected %b %b", bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle(4'd1, 4'($urandom_range(0, 9)), 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
        cycle(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 1'b0, 1'b1);
        checks++;
        if (bus.seg_n !== exp_seg || bus.an_n !== exp_an) begin
          errors++;
          $display("FAIL recapture[%0d.%0d]: seg_n=%b an_n=%b expected %b %b", k, i, bus.seg_n, bus.an_n, exp_seg, exp_an);
        end
      end
    end
  endtask
  task automatic test_update_on_toggle();
    for (int k = 0; k < 3; k++) begin
      while (n % RD != RD - 1) cycle(4'd0, 4'd0, 1'b0, 1'b1);
      cycle(4'd7, 4'd9, 1'b1, 1'b1);
      cycle(4'd3, 4'd3, 1'b0, 1'b1);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an ||
          (bus.seg_n !== 7'b1111000 && bus.seg_n !== 7'b0010000)) begin
        errors++;
        $display("FAIL toggle_update[%0d]: seg_n=%b an_n=%b expected %b %b", k, bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
  endtask
  task automatic test_dash_blank_reset();
    cycle(4'hF, 4'd12, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(4'd0, 4'd0, 1'b0, 1'b1);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an || bus.an_n[1] !== 1'b1) begin
        errors++;
        $display("FAIL dash_blank[%0d]: seg_n=%b an_n=%b expected %b %b", i, bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
    cycle(4'd5, 4'd5, 1'b1, 1'b0);
    checks++;
    if (bus.seg_n !== 7'b1111111 || bus.an_n !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset: seg_n=%b an_n=%b expected 1111111 11", bus.seg_n, bus.an_n);
    end
    cycle(4'd5, 4'd5, 1'b0, 1'b1);
    checks++;
    if (bus.seg_n !== 7'b1000000 || bus.an_n !== 2'b10) begin
      errors++;
      $display("FAIL restart_ones: seg_n=%b an_n=%b expected 1000000 10", bus.seg_n, bus.an_n);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 60) != 0);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an || bus.an_n === 2'b00) begin
        errors++;
        $display("FAIL random[%0d]: seg_n=%b an_n=%b expected %b %b", i, bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
  endtask
`ifdef DISP_BLINK_EN
  task automatic test_blink();
    cycle(4'd6, 4'd3, 1'b1, 1'b0);
    blink_v = 1'b1;
    for (int i = 0; i < 4 * 16 * RD; i++) begin
      cycle(4'd6, 4'd3, 1'b0, 1'b1);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an) begin
        errors++;
        $display("FAIL blink_on[%0d]: seg_n=%b an_n=%b expected %b %b", i, bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
    blink_v = 1'b0;
    for (int i = 0; i < 2 * 16 * RD; i++) begin
      cycle(4'd6, 4'd3, 1'b0, 1'b1);
      checks++;
      if (bus.seg_n !== exp_seg || bus.an_n !== exp_an || bus.an_n === 2'b11) begin
        errors++;
        $display("FAIL blink_off[%0d]: seg_n=%b an_n=%b expected %b %b", i, bus.seg_n, bus.an_n, exp_seg, exp_an);
      end
    end
  endtask
`endif
  initial begin
    bus.tens = 4'd0;
    bus.ones = 4'd0;
    bus.update = 1'b0;
`ifdef DISP_BLINK_EN
    bus.blink = 1'b0;
`endif
    test_reset();
    test_capture();
    test_hold_without_update();
    test_update_on_toggle();
    test_dash_blank_reset();
    test_random();
`ifdef DISP_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
